// File: rtl/core_lsu_port.sv
// LSU initiator port: turns one load/store request into a single word-aligned
// bus transaction, with lane steering, load extension and fault/timeout reporting.
module core_lsu_port #(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clk_en,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_req_we,
  input  logic [2:0]    i_req_funct3,
  input  logic [AW-1:0] i_req_addr,
  input  logic [DW-1:0] i_req_wdata,
  output logic          o_rsp_valid,
  output logic [DW-1:0] o_rsp_rdata,
  output logic          o_rsp_err,
  output logic [1:0]    o_rsp_cause,
  output logic          o_busy,
  output logic          o_lsu_read,
  output logic [AW-1:0] o_r_lsu_addr,
  input  logic [DW-1:0] i_r_lsu_data,
  input  logic          i_lsu_ack,
  output logic          o_lsu_write,
  output logic [AW-1:0] o_w_lsu_addr,
  output logic [3:0]    o_w_lsu_byte_en,
  output logic [DW-1:0] o_w_lsu_data
);

  localparam int unsigned CW = 8;

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FAULT} state_t;

  state_t        state;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [CW-1:0] cnt;

  logic          illegal;
  logic          misaligned;
  logic [AW-1:0] word_addr;
  logic [DW-1:0] st_data;
  logic [3:0]    st_be;
  logic [DW-1:0] shifted;
  logic [DW-1:0] ld_data;
  logic [CW-1:0] cnt_next;

  assign word_addr = {i_req_addr[AW-1:2], 2'b00};
  assign cnt_next  = cnt + CW'(1);

  // Request legality, evaluated on the incoming request before acceptance
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (i_req_we) begin
      illegal = !(i_req_funct3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      illegal = i_req_funct3 inside {3'b011, 3'b110, 3'b111};
    end
    misaligned = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                 ((i_req_funct3 == 3'b010) && (i_req_addr[1:0] != 2'b00));
  end

  // Store lane replication and byte enables
  always_comb begin
    st_data = i_req_wdata;
    st_be   = 4'b1111;
    case (i_req_funct3[1:0])
      2'b00: begin
        st_data = {4{i_req_wdata[7:0]}};
        st_be   = 4'b0001 << i_req_addr[1:0];
      end
      2'b01: begin
        st_data = {2{i_req_wdata[15:0]}};
        st_be   = 4'b0011 << i_req_addr[1:0];
      end
      default: begin
        st_data = i_req_wdata;
        st_be   = 4'b1111;
      end
    endcase
  end

  // Load lane extraction and sign/zero extension
  always_comb begin
    shifted = i_r_lsu_data >> {off_q, 3'b000};
    ld_data = shifted;
    case (f3_q)
      3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ld_data = {24'h000000, shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  ld_data = {16'h0000, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= S_IDLE;
      we_q            <= 1'b0;
      f3_q            <= 3'b000;
      off_q           <= 2'b00;
      cnt             <= '0;
      o_req_ready     <= 1'b1;
      o_busy          <= 1'b0;
      o_rsp_valid     <= 1'b0;
      o_rsp_rdata     <= '0;
      o_rsp_err       <= 1'b0;
      o_rsp_cause     <= 2'b00;
      o_lsu_read      <= 1'b0;
      o_r_lsu_addr    <= '0;
      o_lsu_write     <= 1'b0;
      o_w_lsu_addr    <= '0;
      o_w_lsu_byte_en <= 4'b0000;
      o_w_lsu_data    <= '0;
    end else if (i_clk_en) begin
      // Pulses default low; response fields are zero unless a response fires
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
      o_rsp_cause <= 2'b00;
      o_lsu_read  <= 1'b0;
      o_lsu_write <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_req_valid) begin
            we_q        <= i_req_we;
            f3_q        <= i_req_funct3;
            off_q       <= i_req_addr[1:0];
            o_req_ready <= 1'b0;
            o_busy      <= 1'b1;
            if (illegal || misaligned) begin
              state       <= S_FAULT;
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= 1'b1;
              o_rsp_cause <= illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
            end else begin
              state <= S_ISSUE;
              if (i_req_we) begin
                o_lsu_write     <= 1'b1;
                o_w_lsu_addr    <= word_addr;
                o_w_lsu_byte_en <= st_be;
                o_w_lsu_data    <= st_data;
              end else begin
                o_lsu_read   <= 1'b1;
                o_r_lsu_addr <= word_addr;
              end
            end
          end
        end
        S_ISSUE: begin
          // Responder latency is at least one cycle, so ack is not sampled here
          state <= S_WAIT;
          cnt   <= '0;
        end
        S_WAIT: begin
          if (i_lsu_ack) begin
            state       <= S_IDLE;
            o_req_ready <= 1'b1;
            o_busy      <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_rdata <= we_q ? '0 : ld_data;
          end else if (cnt_next == CW'(TIMEOUT_CYCLES)) begin
            state       <= S_IDLE;
            o_req_ready <= 1'b1;
            o_busy      <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b1;
            o_rsp_cause <= CAUSE_TIMEOUT;
          end else begin
            cnt <= cnt_next;
          end
        end
        S_FAULT: begin
          state       <= S_IDLE;
          o_req_ready <= 1'b1;
          o_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/core_lsu_port.md
Name: core_lsu_port

Overview:
- Initiator side of the core memory arbiter's LSU read/write port. Converts one execute-stage load/store request into a single word-aligned bus transaction.
- Stores: generates byte enables and replicates write data.
- Loads: extracts the addressed byte/half/word and sign/zero-extends it.
- Faults: reports misaligned or illegal accesses, and bus timeouts when no ack arrives.

Parameters:
- AW, 32, address width.
- DW, 32, data width (fixed at 32 for byte-lane logic).
- TIMEOUT_CYCLES, 15, clock-enabled cycles to wait for ack before a timeout fault (range 1..255).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_clk_en  in  1  global clock enable; all state updates gated by it
- i_req_valid  in  1  execute stage presents a request
- o_req_ready  out  1  high only in IDLE; request accepted when valid&ready&clk_en
- i_req_we  in  1  1=store, 0=load
- i_req_funct3  in  3  RV32I width/sign code
- i_req_addr  in  AW  byte address
- i_req_wdata  in  DW  store data, low-aligned
- o_rsp_valid  out  1  one-cycle response pulse, for both loads and stores
- o_rsp_rdata  out  DW  extended load data; 0 for stores and faults
- o_rsp_err  out  1  response carries a fault
- o_rsp_cause  out  2  01 misaligned, 10 illegal funct3, 11 timeout, 00 none
- o_busy  out  1  high when not in IDLE
- o_lsu_read  out  1  bus read strobe
- o_r_lsu_addr  out  AW  bus read address
- i_r_lsu_data  in  DW  bus read data
- i_lsu_ack  in  1  bus ack, shared by reads and writes
- o_lsu_write  out  1  bus write strobe
- o_w_lsu_addr  out  AW  bus write address
- o_w_lsu_byte_en  out  4  bus write byte enables
- o_w_lsu_data  out  DW  bus write data

Behaviour:
- Reset (async assert, sync release): state=IDLE; every output 0 except o_req_ready=1; timeout counter 0.
- i_clk_en=0: state, counter and all registered outputs hold.
- Strobes and o_rsp_valid are single clk_en-cycle pulses.
- FSM states: IDLE, ISSUE, WAIT, FAULT.
- IDLE, on accept: latch we, funct3, addr[1:0], wdata, word address {addr[AW-1:2],2'b00}.
  - Fault check precedes the bus: illegal funct3 -> FAULT with cause 10. Illegal means loads 011/110/111, or stores other than 000/001/010.
  - Misaligned -> FAULT with cause 01. Misaligned means half (x01) with addr[0]=1, or word (010) with addr[1:0]!=0.
  - Illegal funct3 takes priority over misaligned.
  - Otherwise -> ISSUE.
- FAULT, one cycle:
  - o_rsp_valid=1, o_rsp_err=1, cause set, rdata=0; next state IDLE.
  - No bus strobe is ever issued for a faulted request.
- ISSUE, one cycle: assert exactly one of o_lsu_read or o_lsu_write, with the matching address bus = word address; next state WAIT; counter cleared.
- Store lanes (o = addr[1:0]):
  - SB: data = byte replicated x4, be = 4'b0001<<o.
  - SH: data = half replicated x2, be = 4'b0011<<o.
  - SW: data = wdata, be = 4'b1111.
- Addresses, data and byte enables stay stable from ISSUE until the response.
- WAIT, on i_lsu_ack:
  - Load: s = i_r_lsu_data >> (8*o).
    - LB: sext s[7:0]. LBU: zext s[7:0].
    - LH: sext s[15:0]. LHU: zext s[15:0].
    - LW: s.
  - Store: rdata=0.
  - o_rsp_valid=1, err=0; next state IDLE.
  - An ack in the ISSUE cycle itself is impossible (responder latency ≥1) and is ignored.
- WAIT without ack: counter increments per clk_en cycle. On reaching TIMEOUT_CYCLES: respond err=1, cause 11, rdata=0, go IDLE.
- A late ack arriving in IDLE or FAULT is ignored and must not produce a response.
- Nominal latency (responder acks 2 cycles after the strobe):
  - accept at N, strobe at N+1, ack at N+3, o_rsp_valid at N+4;
  - o_req_ready high again at N+4, so a back-to-back accept is possible at N+4.
- Reset mid-transaction: abandons the request; no response is produced.
- o_busy = (state != IDLE).

Test Plan:
- LW addr 0x0000_0204, bus returns 0xDEADBEEF after 2 cycles -> o_r_lsu_addr=0x204, one read strobe, rsp_valid 4 cycles after accept, rdata=0xDEADBEEF, err=0.
- LB/LBU at addr 0x207 with bus data 0x80_12_34_56 -> LB rdata=0xFFFFFF80; LBU rdata=0x00000080; bus address 0x204.
- SH addr 0x20A wdata 0x0000ABCD -> o_w_lsu_addr=0x208, byte_en=4'b1100, data=0xABCDABCD, rsp_valid on ack with rdata=0.
- LW addr 0x201 -> no strobe, rsp_valid next cycle, err=1, cause=01. Load funct3=011 -> cause=10.
- Read with ack withheld, TIMEOUT_CYCLES=15 -> rsp after 15 WAIT cycles with cause=11. A late ack afterwards -> no extra rsp_valid.
- clk_en low for 3 cycles during WAIT, plus i_rst_n pulsed low mid-WAIT -> state held while enable is low; reset forces IDLE, ready=1, all strobes 0, no response.
